// File: rtl/axi_lite_regfile_slave_if.sv
// axi_lite_regfile_slave_if: AXI4-Lite bus bundle shared by master and register-file slave
interface axi_lite_regfile_slave_if;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi_lite_regfile_slave.sv
// axi_lite_regfile_slave: AXI4-Lite register file with byte strobes, OKAY/SLVERR/DECERR responses
module axi_lite_regfile_slave #(
    parameter int          NUM_REGS  = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rstn,
    axi_lite_regfile_slave_if.slave  bus,
    output logic [32*NUM_REGS-1:0]   regs_flat
);
    localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic {W_COLLECT, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_RESP} rstate_t;

    function automatic logic [1:0] decode(input logic [31:0] a);
        return (a < BASE_ADDR || ((a - BASE_ADDR) >> 2) >= 32'(NUM_REGS)) ? 2'b11 :
               (a[1:0] != 2'b00) ? 2'b10 : 2'b00;
    endfunction

    function automatic logic [IW-1:0] index(input logic [31:0] a);
        return IW'((a - BASE_ADDR) >> 2);
    endfunction

    logic [31:0] regs [NUM_REGS];
    wstate_t     wstate, wstate_n;
    rstate_t     rstate, rstate_n;
    logic        aw_held, w_held, aw_held_n, w_held_n;
    logic [31:0] awaddr_q, wdata_q, awaddr_n, wdata_n;
    logic [3:0]  wstrb_q, wstrb_n;
    logic        awready_n, wready_n, bvalid_n, commit;
    logic [1:0]  bresp_n, wresp;
    logic        arready_n, rvalid_n;
    logic [31:0] rdata_n;
    logic [1:0]  rresp_n, rresp_d;
    logic        aw_hs, w_hs, ar_hs;

    assign aw_hs   = bus.awvalid & bus.awready;
    assign w_hs    = bus.wvalid & bus.wready;
    assign ar_hs   = bus.arvalid & bus.arready;
    assign wresp   = decode(awaddr_n);
    assign rresp_d = decode(bus.araddr);

    // Write channel: collect AW and W in any order, commit once both are held, then hold B until accepted
    always_comb begin
        wstate_n  = wstate;
        aw_held_n = aw_held | aw_hs;
        w_held_n  = w_held | w_hs;
        awaddr_n  = aw_hs ? bus.awaddr : awaddr_q;
        wdata_n   = w_hs ? bus.wdata : wdata_q;
        wstrb_n   = w_hs ? bus.wstrb : wstrb_q;
        bvalid_n  = bus.bvalid;
        bresp_n   = bus.bresp;
        awready_n = 1'b0;
        wready_n  = 1'b0;
        commit    = 1'b0;
        if (wstate == W_COLLECT) begin
            if (aw_held_n && w_held_n) begin
                wstate_n  = W_RESP;
                bvalid_n  = 1'b1;
                bresp_n   = wresp;
                commit    = (wresp == 2'b00);
                aw_held_n = 1'b0;
                w_held_n  = 1'b0;
            end else begin
                awready_n = ~aw_held_n;
                wready_n  = ~w_held_n;
            end
        end else if (bus.bvalid && bus.bready) begin
            wstate_n  = W_COLLECT;
            bvalid_n  = 1'b0;
            awready_n = 1'b1;
            wready_n  = 1'b1;
        end
    end

    // Write channel state and registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wstate      <= W_COLLECT;
            aw_held     <= 1'b0;
            w_held      <= 1'b0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            bus.awready <= 1'b0;
            bus.wready  <= 1'b0;
            bus.bvalid  <= 1'b0;
            bus.bresp   <= 2'b00;
        end else begin
            wstate      <= wstate_n;
            aw_held     <= aw_held_n;
            w_held      <= w_held_n;
            awaddr_q    <= awaddr_n;
            wdata_q     <= wdata_n;
            wstrb_q     <= wstrb_n;
            bus.awready <= awready_n;
            bus.wready  <= wready_n;
            bus.bvalid  <= bvalid_n;
            bus.bresp   <= bresp_n;
        end
    end

    // Register file: byte-lane merge on an OKAY commit only
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
        end else if (commit) begin
            for (int i = 0; i < 4; i++)
                if (wstrb_n[i]) regs[index(awaddr_n)][8*i +: 8] <= wdata_n[8*i +: 8];
        end
    end

    // Read channel: capture data on AR handshake (pre-write value on a same-edge commit), hold R until accepted
    always_comb begin
        rstate_n  = rstate;
        rvalid_n  = bus.rvalid;
        rdata_n   = bus.rdata;
        rresp_n   = bus.rresp;
        arready_n = 1'b0;
        if (rstate == R_IDLE) begin
            if (ar_hs) begin
                rstate_n = R_RESP;
                rvalid_n = 1'b1;
                rresp_n  = rresp_d;
                rdata_n  = (rresp_d == 2'b00) ? regs[index(bus.araddr)] : 32'h0;
            end else begin
                arready_n = 1'b1;
            end
        end else if (bus.rready) begin
            rstate_n  = R_IDLE;
            rvalid_n  = 1'b0;
            arready_n = 1'b1;
        end
    end

    // Read channel state and registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rstate      <= R_IDLE;
            bus.arready <= 1'b0;
            bus.rvalid  <= 1'b0;
            bus.rdata   <= '0;
            bus.rresp   <= 2'b00;
        end else begin
            rstate      <= rstate_n;
            bus.arready <= arready_n;
            bus.rvalid  <= rvalid_n;
            bus.rdata   <= rdata_n;
            bus.rresp   <= rresp_n;
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
        assign regs_flat[32*k +: 32] = regs[k];
    end
endmodule

// File: tb/tb_axi_lite_regfile_slave.sv
// tb_axi_lite_regfile_slave: directed self-checking bench for the AXI4-Lite register file
module tb_axi_lite_regfile_slave;
    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic [255:0] regs_flat;
    logic [255:0] exp_flat;
    int           checks = 0;
    int           passed = 0;

    axi_lite_regfile_slave_if bus();

    axi_lite_regfile_slave #(.NUM_REGS(8), .BASE_ADDR(32'h0000_0000)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .bus       (bus.slave),
        .regs_flat (regs_flat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic [1:0] er);
        bus.awvalid = 1'b1; bus.awaddr = a;
        bus.wvalid = 1'b1; bus.wdata = d; bus.wstrb = s;
        cyc;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        check("wr_bvalid", bus.bvalid, 1);
        check("wr_bresp", bus.bresp, er);
        check("wr_readies_low", {bus.awready, bus.wready}, 0);
        bus.bready = 1'b1;
        cyc;
        bus.bready = 1'b0;
        check("wr_bdone", bus.bvalid, 0);
        check("wr_readies_back", {bus.awready, bus.wready}, 2'b11);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er);
        bus.arvalid = 1'b1; bus.araddr = a;
        cyc;
        bus.arvalid = 1'b0;
        check("rd_rvalid", bus.rvalid, 1);
        check("rd_rdata", bus.rdata, ed);
        check("rd_rresp", bus.rresp, er);
        check("rd_arready_low", bus.arready, 0);
        bus.rready = 1'b1;
        cyc;
        bus.rready = 1'b0;
        check("rd_rdone", bus.rvalid, 0);
        check("rd_arready_back", bus.arready, 1);
    endtask

    initial begin
        bus.awvalid = 0; bus.awaddr = 0; bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0;
        bus.bready = 0; bus.arvalid = 0; bus.araddr = 0; bus.rready = 0;
        #1;
        check("rst_outputs", {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid,
                              bus.bresp, bus.rresp, bus.rdata}, 0);
        check("rst_regs", regs_flat, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check("rst_release_readies_low", {bus.awready, bus.wready, bus.arready}, 0);
        cyc;
        check("rst_readies_up", {bus.awready, bus.wready, bus.arready}, 3'b111);

        // 1: AW and W together
        wr(32'h4, 32'hDEADBEEF, 4'hF, 2'b00);
        check("t1_reg1", regs_flat[63:32], 32'hDEADBEEF);

        // 2: W three cycles ahead of AW, partial strobes
        bus.wvalid = 1'b1; bus.wdata = 32'h11223344; bus.wstrb = 4'b0101;
        cyc;
        bus.wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t2_wait_ready", {bus.awready, bus.wready, bus.bvalid}, 3'b100);
            if (i < 2) cyc;
        end
        bus.awvalid = 1'b1; bus.awaddr = 32'h4;
        cyc;
        bus.awvalid = 1'b0;
        check("t2_bvalid", {bus.bvalid, bus.bresp}, 3'b100);
        check("t2_reg1", regs_flat[63:32], 32'hDE22BE44);
        for (int i = 0; i < 2; i++) begin
            check("t2_readies_low", {bus.awready, bus.wready}, 0);
            cyc;
            check("t2_bvalid_hold", {bus.bvalid, bus.bresp}, 3'b100);
        end
        bus.bready = 1'b1;
        cyc;
        bus.bready = 1'b0;
        check("t2_bdone", bus.bvalid, 0);
        check("t2_readies_back", {bus.awready, bus.wready}, 2'b11);

        // 3: error responses and a no-strobe write leave registers alone
        exp_flat = '0;
        exp_flat[63:32] = 32'hDE22BE44;
        wr(32'h20, 32'hFFFFFFFF, 4'hF, 2'b11);
        check("t3_decerr_noop", regs_flat, exp_flat);
        wr(32'h5, 32'hFFFFFFFF, 4'hF, 2'b10);
        check("t3_slverr_noop", regs_flat, exp_flat);
        wr(32'h4, 32'hFFFFFFFF, 4'h0, 2'b00);
        check("t3_nostrb_noop", regs_flat, exp_flat);
        rd(32'h2, 32'h0, 2'b10);
        rd(32'h40, 32'h0, 2'b11);

        // 4: read held by rready low
        bus.arvalid = 1'b1; bus.araddr = 32'h4;
        cyc;
        bus.arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("t4_hold", {bus.rvalid, bus.arready, bus.rresp, bus.rdata}, {1'b1, 1'b0, 2'b00, 32'hDE22BE44});
            cyc;
        end
        bus.rready = 1'b1;
        cyc;
        bus.rready = 1'b0;
        check("t4_rdone", {bus.rvalid, bus.arready}, 2'b01);

        // 5: same-edge write commit and read capture of reg1
        bus.awvalid = 1'b1; bus.awaddr = 32'h4;
        bus.wvalid = 1'b1; bus.wdata = 32'hA5A5A5A5; bus.wstrb = 4'hF;
        bus.arvalid = 1'b1; bus.araddr = 32'h4;
        cyc;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        check("t5_old_rdata", bus.rdata, 32'hDE22BE44);
        check("t5_both_valid", {bus.bvalid, bus.rvalid}, 2'b11);
        check("t5_reg1_new", regs_flat[63:32], 32'hA5A5A5A5);
        bus.bready = 1'b1; bus.rready = 1'b1;
        cyc;
        bus.bready = 1'b0; bus.rready = 1'b0;
        rd(32'h4, 32'hA5A5A5A5, 2'b00);

        // 6: async reset with both responses pending
        bus.awvalid = 1'b1; bus.awaddr = 32'h0;
        bus.wvalid = 1'b1; bus.wdata = 32'h12345678; bus.wstrb = 4'hF;
        bus.arvalid = 1'b1; bus.araddr = 32'h4;
        cyc;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        check("t6_pending", {bus.bvalid, bus.rvalid}, 2'b11);
        #2;
        rstn = 1'b0;
        #1;
        check("t6_rst_outputs", {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid,
                                 bus.bresp, bus.rresp, bus.rdata}, 0);
        check("t6_rst_regs", regs_flat, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check("t6_release_low", {bus.awready, bus.wready, bus.arready}, 0);
        cyc;
        check("t6_readies_up", {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid}, 5'b11100);
        rd(32'h0, 32'h0, 2'b00);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
